audio_fifo_unpacker: RTL
========================

AUDIO_FIFO_UNPACKER -- requirements
Module: audio_fifo_unpacker

Interface
REQ-001 Parameter LSB_FIRST, default 1, byte order: 1 = bits [7:0] emitted first, 0 = bits [15:8] emitted first.
REQ-002 rd_clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rd_rst_n  input  1  asynchronous, active-low reset.
REQ-004 soft_clr  input  1  synchronous flush, active high.
REQ-005 fifo_rd_en  output  1  read strobe to upstream 16-bit FIFO read port.
REQ-006 fifo_rd_data  input  16  FIFO read data, valid exactly one cycle after the fifo_rd_en cycle.
REQ-007 fifo_rd_empty  input  1  FIFO empty flag.
REQ-008 m_valid  output  1  byte-stream valid.
REQ-009 m_data  output  8  byte-stream data.
REQ-010 m_ready  input  1  byte-stream ready.
REQ-011 m_first  output  1  high while m_data is the first byte of a word.
REQ-012 word_cnt  output  16  count of words fully emitted.

Function
REQ-013 Storage shall be two 16-bit word slots: cur (being emitted) and nxt (pending), each with a valid bit; byte_sel shall select the byte within cur.
REQ-014 fifo_rd_en shall be combinational: !fifo_rd_empty && !soft_clr && (cur_v + nxt_v + inflight) < 2.
- inflight = 1 in the cycle after a fifo_rd_en cycle.
REQ-015 Returned data shall be captured at the end of the inflight cycle.
- Goes into cur if cur is empty or its last byte handshakes that cycle; otherwise into nxt.
REQ-016 Handshake shall occur on any cycle with m_valid && m_ready.
- m_data and m_first shall hold stable while m_valid && !m_ready.
REQ-017 m_valid shall equal cur_v (registered); m_data = byte selected by byte_sel and LSB_FIRST; m_first = (byte_sel == 0).
REQ-018 On a handshake with byte_sel = 0, byte_sel shall become 1.
REQ-019 On a handshake with byte_sel = 1:
- byte_sel shall return to 0 and word_cnt shall increment, wrapping 0xFFFF -> 0x0000.
- cur shall load from nxt if nxt_v (nxt_v cleared), else from concurrently arriving data, else cur_v shall clear.
REQ-020 Latency: first m_valid shall assert two cycles after the fifo_rd_en cycle when the unpacker is empty.
REQ-021 Throughput: with fifo_rd_empty held 0 and m_ready held 1, m_valid shall stay high continuously after first assertion (one byte per cycle, fifo_rd_en every second cycle).
REQ-022 Backpressure: with m_ready held 0, no more than 2 words shall ever be read; fifo_rd_en shall stay 0 once cur_v and nxt_v are both set.
REQ-023 fifo_rd_empty rising mid-word shall not affect emission of already-stored bytes.
- When the FIFO is empty and both slots are empty, m_valid shall drop after the last byte.
REQ-024 soft_clr shall clear cur_v, nxt_v and byte_sel in the next cycle and shall suppress fifo_rd_en.
- Data returning for a read issued before soft_clr shall be discarded.
- word_cnt shall be cleared to 0.
- A handshake coinciding with soft_clr shall not increment word_cnt.

Reset
REQ-025 While rd_rst_n = 0, fifo_rd_en shall be 0 combinationally.
REQ-026 rd_rst_n = 0 shall asynchronously set m_valid = 0, m_data = 0x00, m_first = 1, word_cnt = 0, cur_v = nxt_v = 0, byte_sel = 0, inflight = 0.
REQ-027 Reset asserted mid-word shall drop the partial word.
- After release, operation shall resume from the next FIFO word with no residual byte.

Verification
REQ-028 Single word: FIFO holds 0xA55A, LSB_FIRST = 1, m_ready = 1.
- fifo_rd_en pulses once.
- m_data = 0x5A (m_first = 1), then 0xA5 (m_first = 0), on consecutive cycles starting 2 cycles after fifo_rd_en.
- word_cnt = 1.
REQ-029 Streaming: FIFO holds 0x0100..0x0163 (100 words), m_ready = 1.
- Exactly 200 bytes on 200 consecutive cycles, with no m_valid gap.
- word_cnt = 100.
REQ-030 Backpressure: FIFO non-empty, m_ready = 0 for 20 cycles.
- Exactly 2 fifo_rd_en pulses occur.
- m_data is stable throughout.
- After m_ready = 1, bytes are in order with none lost.
REQ-031 LSB_FIRST = 0 with word 0x1234: m_data = 0x12 then 0x34.
REQ-032 soft_clr asserted in the cycle after a fifo_rd_en, while holding a half-emitted word.
- Next cycle: m_valid = 0, word_cnt = 0.
- The in-flight word is never emitted.
- The following FIFO word emits normally.
REQ-033 word_cnt at 0xFFFF plus one complete word gives 0x0000; rd_rst_n pulse mid-word gives all outputs per REQ-026 within the same cycle.

Source files
------------

// File: rtl/audio_fifo_unpacker.sv
// Unpacks 16-bit words read from a synchronous-read FIFO into a byte stream.
// Two word slots (cur/nxt) plus one in-flight read keep the output gapless.
module audio_fifo_unpacker #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        rd_clk,
  input  logic        rd_rst_n,
  input  logic        soft_clr,
  output logic        fifo_rd_en,
  input  logic [15:0] fifo_rd_data,
  input  logic        fifo_rd_empty,
  output logic        m_valid,
  output logic [7:0]  m_data,
  input  logic        m_ready,
  output logic        m_first,
  output logic [15:0] word_cnt
);

  logic [15:0] cur_q, cur_d;
  logic [15:0] nxt_q, nxt_d;
  logic        cur_v_q, cur_v_d;
  logic        nxt_v_q, nxt_v_d;
  logic        byte_sel_q, byte_sel_d;
  logic        inflight_q, inflight_d;
  logic [15:0] word_cnt_q, word_cnt_d;

  logic [1:0]  occupancy;
  logic        hs;
  logic        last_hs;
  logic        hi_sel;

  always_comb begin
    occupancy  = {1'b0, cur_v_q} + {1'b0, nxt_v_q} + {1'b0, inflight_q};
    // Reset gating keeps the strobe quiet even before the state registers settle.
    fifo_rd_en = rd_rst_n && !fifo_rd_empty && !soft_clr && (occupancy < 2'd2);
    hs         = cur_v_q && m_ready;
    last_hs    = hs && byte_sel_q;
  end

  always_comb begin
    cur_d      = cur_q;
    nxt_d      = nxt_q;
    cur_v_d    = cur_v_q;
    nxt_v_d    = nxt_v_q;
    byte_sel_d = byte_sel_q;
    word_cnt_d = word_cnt_q;
    inflight_d = fifo_rd_en;

    if (soft_clr) begin
      // Returning data in this cycle belongs to a pre-flush read and is dropped.
      cur_v_d    = 1'b0;
      nxt_v_d    = 1'b0;
      byte_sel_d = 1'b0;
      word_cnt_d = 16'd0;
    end else begin
      if (hs) begin
        byte_sel_d = !byte_sel_q;
      end
      if (last_hs) begin
        word_cnt_d = word_cnt_q + 16'd1;
        if (nxt_v_q) begin
          cur_d   = nxt_q;
          nxt_v_d = 1'b0;
        end else if (inflight_q) begin
          cur_d = fifo_rd_data;
        end else begin
          cur_v_d = 1'b0;
        end
      end
      // Arrival not already consumed by the cur refill above.
      if (inflight_q && !(last_hs && !nxt_v_q)) begin
        if (!cur_v_q) begin
          cur_d   = fifo_rd_data;
          cur_v_d = 1'b1;
        end else begin
          nxt_d   = fifo_rd_data;
          nxt_v_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      cur_q      <= 16'd0;
      nxt_q      <= 16'd0;
      cur_v_q    <= 1'b0;
      nxt_v_q    <= 1'b0;
      byte_sel_q <= 1'b0;
      inflight_q <= 1'b0;
      word_cnt_q <= 16'd0;
    end else begin
      cur_q      <= cur_d;
      nxt_q      <= nxt_d;
      cur_v_q    <= cur_v_d;
      nxt_v_q    <= nxt_v_d;
      byte_sel_q <= byte_sel_d;
      inflight_q <= inflight_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  always_comb begin
    hi_sel   = byte_sel_q ^ !LSB_FIRST;
    m_valid  = cur_v_q;
    m_data   = hi_sel ? cur_q[15:8] : cur_q[7:0];
    m_first  = !byte_sel_q;
    word_cnt = word_cnt_q;
  end

endmodule
